// File: rtl/stack_pkg.sv
// Shared definitions for the microprogram sequencer stack: opcodes, FSM states
// and default widths.
package stack_pkg;

   localparam int DEF_DW = 12;
   localparam int DEF_AW = 3;

   localparam logic [1:0] CMD_NOP   = 2'b00;
   localparam logic [1:0] CMD_PUSH  = 2'b01;
   localparam logic [1:0] CMD_POP   = 2'b10;
   localparam logic [1:0] CMD_CLEAR = 2'b11;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_POP_WAIT = 1'b1
   } state_e;

endpackage

// File: rtl/upc_stack_ctrl.sv
// Subroutine/loop stack control: TOS held in a register, deeper entries spilled
// to an external single-port RAM with 1-cycle registered read data.
module upc_stack_ctrl
   import stack_pkg::*;
#(
   parameter int DW    = DEF_DW,
   parameter int AW    = DEF_AW,
   parameter int DEPTH = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [1:0]    cmd,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [DW-1:0] push_data,
   output logic [DW-1:0] tos,
   output logic [3:0]    count,
   output logic          full_n,
   output logic          empty,
   output logic          ovf,
   output logic          unf,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_din,
   input  logic [DW-1:0] mem_dout
);

   localparam logic [3:0] DEPTH_C = 4'(DEPTH);

   state_e        r_state;
   logic [DW-1:0] r_tos;
   logic [3:0]    r_count;
   logic          r_full_n;
   logic          r_empty;
   logic          r_ovf;
   logic          r_unf;
   logic          r_cmd_ready;

   logic          w_accept;
   logic          w_is_full;
   logic          w_is_empty;
   logic [3:0]    w_count_nxt;
   logic          w_mem_we;
   logic [AW-1:0] w_mem_addr;
   logic [DW-1:0] w_mem_din;

   assign w_accept   = cmd_valid && r_cmd_ready;
   assign w_is_full  = (r_count == DEPTH_C);
   assign w_is_empty = (r_count == 4'd0);

   // RAM port drive: the spill write and the pop read address are both issued
   // in the accept cycle so the read data is ready during POP_WAIT.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can
      // leave it unassigned and infer a latch.
      w_mem_we   = 1'b0;
      w_mem_addr = '0;
      w_mem_din  = '0;
      if (w_accept) begin
         case (cmd)
            CMD_PUSH: begin
               if (!w_is_empty && !w_is_full) begin
                  w_mem_we   = 1'b1;
                  w_mem_addr = AW'(r_count - 4'd1);
                  w_mem_din  = r_tos;
               end
            end
            CMD_POP: begin
               if (r_count >= 4'd2) begin
                  w_mem_addr = AW'(r_count - 4'd2);
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_count_nxt = r_count;
      if (r_state == ST_POP_WAIT) begin
         w_count_nxt = r_count - 4'd1;
      end else if (w_accept) begin
         case (cmd)
            CMD_PUSH:  if (!w_is_full) w_count_nxt = r_count + 4'd1;
            CMD_POP:   if (r_count == 4'd1) w_count_nxt = 4'd0;
            CMD_CLEAR: w_count_nxt = 4'd0;
            default:   ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_tos       <= '0;
         r_count     <= 4'd0;
         r_full_n    <= 1'b1;
         r_empty     <= 1'b1;
         r_ovf       <= 1'b0;
         r_unf       <= 1'b0;
         r_cmd_ready <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments throughout, so every register sees
         // the pre-edge values of the others regardless of statement order.
         r_count  <= w_count_nxt;
         r_full_n <= (w_count_nxt != DEPTH_C);
         r_empty  <= (w_count_nxt == 4'd0);
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  case (cmd)
                     CMD_PUSH: begin
                        r_tos <= push_data;
                        r_ovf <= w_is_full;
                     end
                     CMD_POP: begin
                        if (r_count >= 4'd2) begin
                           r_state     <= ST_POP_WAIT;
                           r_cmd_ready <= 1'b0;
                        end else if (r_count == 4'd1) begin
                           r_tos <= '0;
                        end else begin
                           r_unf <= 1'b1;
                        end
                     end
                     CMD_CLEAR: r_tos <= '0;
                     default:   ;
                  endcase
               end
            end
            ST_POP_WAIT: begin
               r_tos       <= mem_dout;
               r_state     <= ST_IDLE;
               r_cmd_ready <= 1'b1;
            end
            default: begin
               r_state     <= ST_IDLE;
               r_cmd_ready <= 1'b1;
            end
         endcase
      end
   end

   assign cmd_ready = r_cmd_ready;
   assign tos       = r_tos;
   assign count     = r_count;
   assign full_n    = r_full_n;
   assign empty     = r_empty;
   assign ovf       = r_ovf;
   assign unf       = r_unf;
   assign mem_we    = w_mem_we;
   assign mem_addr  = w_mem_addr;
   assign mem_din   = w_mem_din;

endmodule

// File: tb/tb_upc_stack_ctrl.sv
// Directed bench for upc_stack_ctrl with a behavioural 8x12 registered-read RAM.
module tb_upc_stack_ctrl;
   import stack_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  cmd;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [11:0] push_data;
   logic [11:0] tos;
   logic [3:0]  count;
   logic        full_n;
   logic        empty;
   logic        ovf;
   logic        unf;
   logic        mem_we;
   logic [2:0]  mem_addr;
   logic [11:0] mem_din;
   logic [11:0] mem_dout;

   logic [11:0] ram [8];
   int          wr_count = 0;
   int          n_checks = 0;
   int          n_pass   = 0;

   always #5 clk = ~clk;

   upc_stack_ctrl #(.DW(12), .AW(3), .DEPTH(5)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd       (cmd),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .push_data (push_data),
      .tos       (tos),
      .count     (count),
      .full_n    (full_n),
      .empty     (empty),
      .ovf       (ovf),
      .unf       (unf),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_din   (mem_din),
      .mem_dout  (mem_dout)
   );

   // Read-first single-port RAM, registered read data.
   always @(posedge clk) begin
      if (mem_we) begin
         ram[mem_addr] <= mem_din;
         wr_count      <= wr_count + 1;
      end
      mem_dout <= ram[mem_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Present a command for one edge; returns at the following negedge.
   task automatic issue(input logic [1:0] c, input logic [11:0] d);
      cmd       = c;
      push_data = d;
      cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd       = CMD_NOP;
   endtask

   task automatic pop_deep(input string tag, input logic [11:0] exp_tos, input logic [3:0] exp_cnt);
      issue(CMD_POP, 12'h0);
      check({tag, "_busy"}, cmd_ready, 0);
      @(posedge clk);
      @(negedge clk);
      check({tag, "_tos"}, tos, exp_tos);
      check({tag, "_cnt"}, count, exp_cnt);
      check({tag, "_rdy"}, cmd_ready, 1);
   endtask

   initial begin
      rst_n     = 1'b0;
      cmd       = CMD_NOP;
      cmd_valid = 1'b0;
      push_data = '0;
      repeat (2) @(negedge clk);
      check("rst_tos", tos, 0);
      check("rst_cnt", count, 0);
      check("rst_full_n", full_n, 1);
      check("rst_empty", empty, 1);
      check("rst_ovf", ovf, 0);
      check("rst_unf", unf, 0);
      check("rst_we", mem_we, 0);
      check("rst_rdy", cmd_ready, 1);
      rst_n = 1'b1;
      @(negedge clk);

      // Three back-to-back pushes spill the two older entries.
      issue(CMD_PUSH, 12'h100);
      issue(CMD_PUSH, 12'h101);
      issue(CMD_PUSH, 12'h102);
      check("p3_tos", tos, 12'h102);
      check("p3_cnt", count, 3);
      check("p3_ram0", ram[0], 12'h100);
      check("p3_ram1", ram[1], 12'h101);
      check("p3_wr", wr_count, 2);
      check("p3_empty", empty, 0);

      pop_deep("pop1", 12'h101, 2);
      pop_deep("pop2", 12'h100, 1);
      issue(CMD_POP, 12'h0);
      check("pop3_tos", tos, 0);
      check("pop3_cnt", count, 0);
      check("pop3_empty", empty, 1);
      check("pop3_rdy", cmd_ready, 1);

      // Fill to capacity, then overflow overwrites TOS only.
      for (int i = 1; i <= 5; i++) issue(CMD_PUSH, 12'(i));
      check("full_cnt", count, 5);
      check("full_n", full_n, 0);
      check("full_wr", wr_count, 6);
      issue(CMD_PUSH, 12'hABC);
      check("ovf_tos", tos, 12'hABC);
      check("ovf_cnt", count, 5);
      check("ovf_pulse", ovf, 1);
      check("ovf_wr", wr_count, 6);
      @(negedge clk);
      check("ovf_clear", ovf, 0);
      pop_deep("dpop4", 12'h004, 4);
      check("dpop4_full_n", full_n, 1);
      pop_deep("dpop3", 12'h003, 3);
      pop_deep("dpop2", 12'h002, 2);
      pop_deep("dpop1", 12'h001, 1);
      issue(CMD_POP, 12'h0);
      check("drain_cnt", count, 0);

      // Underflow.
      issue(CMD_POP, 12'h0);
      check("unf_pulse", unf, 1);
      check("unf_tos", tos, 0);
      check("unf_cnt", count, 0);
      check("unf_rdy", cmd_ready, 1);
      @(negedge clk);
      check("unf_clear", unf, 0);

      // Clear.
      issue(CMD_PUSH, 12'h007);
      issue(CMD_PUSH, 12'h008);
      issue(CMD_PUSH, 12'h009);
      check("clr_pre_cnt", count, 3);
      issue(CMD_CLEAR, 12'h0);
      check("clr_cnt", count, 0);
      check("clr_tos", tos, 0);
      check("clr_empty", empty, 1);

      // Reset during POP_WAIT abandons the read.
      issue(CMD_PUSH, 12'h011);
      issue(CMD_PUSH, 12'h022);
      issue(CMD_POP, 12'h0);
      check("rpw_busy", cmd_ready, 0);
      rst_n = 1'b0;
      #1;
      check("rpw_tos", tos, 0);
      check("rpw_cnt", count, 0);
      check("rpw_rdy", cmd_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("rpw_post_tos", tos, 0);
      check("rpw_post_cnt", count, 0);

      // Alternate push/pop around count==2.
      issue(CMD_PUSH, 12'h200);
      issue(CMD_PUSH, 12'h201);
      for (int i = 0; i < 3; i++) begin
         issue(CMD_PUSH, 12'h0AA);
         check("alt_push_tos", tos, 12'h0AA);
         check("alt_push_cnt", count, 3);
         check("alt_ram1", ram[1], 12'h201);
         pop_deep("alt_pop", 12'h201, 2);
      end
      check("alt_ram0", ram[0], 12'h200);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
